fxp_dot_seq: RTL
================

# fxp_dot_seq

Sequencer that computes a signed fixed-point dot product of two vectors held in single-port-read memories. It time-shares one N.M signed multiplier across all element pairs. Given a start command with base addresses and length, it issues reads, multiplies each pair, accumulates, and presents the scalar result through a valid/ready handshake. It sits between the layer controller and the weight/activation RAMs, one instance per neuron lane of the CNN datapath.

## Interface
- N, 5, integer bits including sign
- M, 22, fractional bits; word width W = N+M
- ADDR_W, 10, memory address width
- LEN_W, 10, width of length field (max vector length 2^LEN_W − 1)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- len  in  LEN_W  number of element pairs
- base_a  in  ADDR_W  first address of vector A
- base_b  in  ADDR_W  first address of vector B
- busy  out  1  high in every state except IDLE
- rd_en  out  1  read strobe for both memories
- addr_a  out  ADDR_W  vector A read address
- addr_b  out  ADDR_W  vector B read address
- rd_data_a  in  W  signed A word; valid the cycle after rd_en
- rd_data_b  in  W  signed B word; valid the cycle after rd_en
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  W  signed N.M dot product

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1, len≠0:
  - latch len, base_a, base_b
  - clear accumulator and element counter
  - go to RUN
- IDLE, start=1, len=0: go straight to DONE with result=0.
- RUN:
  - rd_en=1; addr_a=base_a+i, addr_b=base_b+i for i=0..len−1, one pair per cycle
  - after i=len−1, go to DRAIN
- DRAIN: exactly 2 cycles with rd_en=0, flushing the product and accumulate stages. Then go to DONE.
- DONE:
  - out_valid=1; result holds the accumulator
  - when out_valid && out_ready, return to IDLE
  - start is ignored
- start in any state other than IDLE is ignored. It is not queued.
- Address arithmetic wraps modulo 2^ADDR_W.
- Multiply:
  - full 2W-bit signed product p
  - truncated result = {p[2W−1], p[M+W−2 : M]}
  - integer overflow is discarded and truncation is toward −∞
- Accumulate: W-bit signed add, wrap-around on overflow (see Configuration).
- reset in any state:
  - next state IDLE
  - all pipeline valid bits cleared, accumulator cleared
  - in-flight reads are dropped

## Timing
- Reset values:
  - busy=0, rd_en=0, addr_a=0, addr_b=0, out_valid=0, result=0
- Cycle 0: start sampled in IDLE.
- Cycles 1..L: rd_en high, pair i issued in cycle i+1.
- Pipeline for the pair issued in cycle k:
  - data arrives in cycle k+1
  - product register is valid in cycle k+2
  - accumulator is updated at the end of cycle k+2
- out_valid rises in cycle L+3 and holds until accepted. result is stable while out_valid=1.
- len=0: out_valid rises in cycle 1.
- Back-to-back operation: the earliest next start is the cycle after handshake completion, because the block is then in IDLE.
- busy=1 from cycle 1 through the handshake cycle inclusive.

## Configuration
- FXP_DOT_SAT_EN defined:
  - the accumulator saturates
  - positive overflow clamps to 2^(W−1)−1 (27'h3FFFFFF at default W)
  - negative overflow clamps to −2^(W−1) (27'h4000000)
  - a sticky output sat_flag (1 bit) is added; it is cleared on start and set on any clamp
- FXP_DOT_SAT_EN undefined: two's-complement wrap and no sat_flag port.
- Multiplier truncation is identical in both builds.

## Structure
- Shared package fxp_pkg holds:
  - N, M, W defaults
  - state encoding constants (IDLE=0, RUN=1, DRAIN=2, DONE=3)
  - ONE = 1<<M
  - saturation limits
- Sub-module fxp_signed_mult: combinational W×W signed multiply with the truncation rule above. fxp_dot_seq registers its output.
- Controller FSM, counter, address generation, pipeline valids and accumulator live in fxp_dot_seq.

## Test plan
- len=1:
  - stimulus: A[0]=27'h0600000 (1.5), B[0]=27'h7C80000 (−0.875)
  - response: result=27'h7AC0000 (−1.3125), out_valid at cycle 4
- len=4, all A=B=27'h0400000 (1.0):
  - response: rd_en high cycles 1–4 with addresses base..base+3
  - response: result=27'h1000000 (4.0), out_valid at cycle 7
- len=0:
  - response: out_valid at cycle 1, result=0, rd_en never asserted
- Backpressure:
  - stimulus: hold out_ready=0 for 10 cycles after out_valid; assert start during the stall
  - response: result stable, start ignored, busy=1; IDLE the cycle after out_ready=1
- Wrap and saturation:
  - stimulus: len=3, each product 27'h1800000 (6.0), sum 18.0 exceeds the +15.99 range
  - response without macro: wrapped value 27'h4800000
  - response with FXP_DOT_SAT_EN: 27'h3FFFFFF and sat_flag=1
- Reset mid-RUN:
  - stimulus: assert reset in cycle 3 of a len=8 run
  - response: next cycle IDLE, rd_en=0, out_valid=0
  - response: a following len=1 run produces the correct product, not contaminated by prior partial sums

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared fixed-point defaults, sequencer state encoding and saturation limits
// for the dot-product sequencer.
package fxp_pkg;

    localparam int unsigned FXP_N = 5;
    localparam int unsigned FXP_M = 22;
    localparam int unsigned FXP_W = FXP_N + FXP_M;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [FXP_W-1:0] ONE     = FXP_W'(1) << FXP_M;
    localparam logic [FXP_W-1:0] SAT_MAX = {1'b0, {(FXP_W-1){1'b1}}};
    localparam logic [FXP_W-1:0] SAT_MIN = {1'b1, {(FXP_W-1){1'b0}}};

endpackage

// File: rtl/fxp_signed_mult.sv
// Combinational N.M x N.M signed multiply; keeps the sign bit and the W-1 bits
// above the fraction, so integer overflow is dropped and rounding is toward -inf.
module fxp_signed_mult
    import fxp_pkg::*;
#(
    parameter int unsigned N = FXP_N,
    parameter int unsigned M = FXP_M
) (
    input  logic signed [N+M-1:0] a,
    input  logic signed [N+M-1:0] b,
    output logic signed [N+M-1:0] p
);

    localparam int unsigned W = N + M;

    logic signed [2*W-1:0] full;
    logic                  unused_bits;

    assign full        = a * b;
    assign p           = {full[2*W-1], full[M+W-2:M]};
    assign unused_bits = ^{full[2*W-2:M+W-1], full[M-1:0]};

endmodule

// File: rtl/fxp_dot_seq.sv
// Sequential fixed-point dot product over two single-port memories.
// Define FXP_DOT_SAT_EN for a saturating accumulator with a sticky sat_flag output.
module fxp_dot_seq
    import fxp_pkg::*;
#(
    parameter int unsigned N      = FXP_N,
    parameter int unsigned M      = FXP_M,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 10,
    localparam int unsigned W     = N + M
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    input  logic [W-1:0]      rd_data_a,
    input  logic [W-1:0]      rd_data_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      result
`ifdef FXP_DOT_SAT_EN
    ,
    output logic              sat_flag
`endif
);

    state_t            state, state_nx;
    logic [LEN_W-1:0]  len_q, cnt;
    logic [ADDR_W-1:0] base_a_q, base_b_q;
    logic              drain_q;
    logic              v1, v2;
    logic [W-1:0]      prod, prod_q, acc, acc_nx;
    logic              accept;
    logic              ovf;

    assign accept = (state == IDLE) && start;

    fxp_signed_mult #(.N(N), .M(M)) u_mult (
        .a (rd_data_a),
        .b (rd_data_b),
        .p (prod)
    );

    always_comb begin
        state_nx  = state;
        busy      = 1'b1;
        rd_en     = 1'b0;
        out_valid = 1'b0;
        addr_a    = base_a_q + ADDR_W'(cnt);
        addr_b    = base_b_q + ADDR_W'(cnt);
        result    = acc;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = (len != '0) ? RUN : DONE;
            end
            RUN: begin
                rd_en = 1'b1;
                if (cnt == len_q - LEN_W'(1)) state_nx = DRAIN;
            end
            DRAIN: begin
                if (drain_q) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q    <= '0;
            cnt      <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            drain_q  <= 1'b0;
        end else begin
            if (accept) begin
                len_q    <= len;
                base_a_q <= base_a;
                base_b_q <= base_b;
                cnt      <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + LEN_W'(1);
            end
            // drain_q marks the second DRAIN cycle
            drain_q <= (state == DRAIN) ? ~drain_q : 1'b0;
        end
    end

`ifdef FXP_DOT_SAT_EN
    localparam logic [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};
    logic [W-1:0] sum;

    always_comb begin
        sum    = acc + prod_q;
        ovf    = (acc[W-1] == prod_q[W-1]) && (sum[W-1] != acc[W-1]);
        acc_nx = ovf ? (acc[W-1] ? ACC_MIN : ACC_MAX) : sum;
    end
`else
    always_comb begin
        ovf    = 1'b0;
        acc_nx = acc + prod_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            prod_q <= '0;
            acc    <= '0;
`ifdef FXP_DOT_SAT_EN
            sat_flag <= 1'b0;
`endif
        end else begin
            v1 <= rd_en;
            v2 <= v1;
            if (v1) prod_q <= prod;
            if (accept) begin
                acc <= '0;
`ifdef FXP_DOT_SAT_EN
                sat_flag <= 1'b0;
`endif
            end else if (v2) begin
                acc <= acc_nx;
`ifdef FXP_DOT_SAT_EN
                sat_flag <= sat_flag | ovf;
`endif
            end
        end
    end

`ifndef FXP_DOT_SAT_EN
    logic unused_ovf;
    assign unused_ovf = ovf;
`endif

endmodule
